// File: rtl/branch_predictor_pkg.sv
// branch_predictor_pkg: shared constants and counter encodings for the IF-stage predictor.
package branch_predictor_pkg;
  localparam int PC_STEP = 4;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
  function automatic int cnt_wnt(input int w);
    return (1 << (w - 1)) - 1;
  endfunction
  function automatic int cnt_wt(input int w);
    return 1 << (w - 1);
  endfunction
  function automatic int cnt_max(input int w);
    return (1 << w) - 1;
  endfunction
endpackage

// File: rtl/branch_predictor_if.sv
// branch_predictor_if: lookup, resolve-update and perf-counter signals between the core and the predictor.
interface branch_predictor_if #(
  parameter int XLEN   = 32,
  parameter int PERF_W = 32
);
  logic              start_i;
  logic [XLEN-1:0]   lookup_pc_i;
  logic              pred_hit_o;
  logic              pred_taken_o;
  logic [XLEN-1:0]   pred_target_o;
  logic              upd_valid_i;
  logic [XLEN-1:0]   upd_pc_i;
  logic              upd_taken_i;
  logic              upd_uncond_i;
  logic [XLEN-1:0]   upd_target_i;
  logic              upd_mispredict_i;
  logic [PERF_W-1:0] lookup_cnt_o;
  logic [PERF_W-1:0] mispredict_cnt_o;
  modport master (
    output start_i, lookup_pc_i, upd_valid_i, upd_pc_i, upd_taken_i, upd_uncond_i, upd_target_i, upd_mispredict_i,
    input  pred_hit_o, pred_taken_o, pred_target_o, lookup_cnt_o, mispredict_cnt_o
  );
  modport slave (
    input  start_i, lookup_pc_i, upd_valid_i, upd_pc_i, upd_taken_i, upd_uncond_i, upd_target_i, upd_mispredict_i,
    output pred_hit_o, pred_taken_o, pred_target_o, lookup_cnt_o, mispredict_cnt_o
  );
endinterface

// File: rtl/branch_predictor_sat_counter.sv
// branch_predictor_sat_counter: per-entry saturating direction counter, resets weakly not-taken.
module branch_predictor_sat_counter
  import branch_predictor_pkg::*;
#(
  parameter int W = 2
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc_i,
  input  logic         dec_i,
  input  logic         set_max_i,
  input  logic         load_i,
  output logic [W-1:0] cnt_o
);
  localparam logic [W-1:0] MAX = W'(cnt_max(W));
  logic [W-1:0] cnt_d, cnt_q;
  always_comb begin
    cnt_d = set_max_i ? MAX :
            load_i ? W'(cnt_wt(W)) :
            (inc_i && cnt_q != MAX) ? cnt_q + 1'b1 :
            (dec_i && cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
  end
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) cnt_q <= W'(cnt_wnt(W));
    else cnt_q <= cnt_d;
  end
  assign cnt_o = cnt_q;
endmodule

// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped BTB with per-entry saturating BHT, same-cycle prediction for IF.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int ENTRIES = 16,
  parameter int TAG_W   = 8,
  parameter int CNT_W   = 2,
  parameter int PERF_W  = 32
) (
  input logic               clk_i,
  input logic               rst_i,
  branch_predictor_if.slave bp
);
  localparam int IDX_W = clog2(ENTRIES);
  logic [IDX_W-1:0]  l_idx, u_idx;
  logic [TAG_W-1:0]  l_tag, u_tag;
  logic [ENTRIES-1:0] valid_d, valid_q;
  logic [TAG_W-1:0]  tag_d [ENTRIES];
  logic [TAG_W-1:0]  tag_q [ENTRIES];
  logic [XLEN-1:0]   tgt_d [ENTRIES];
  logic [XLEN-1:0]   tgt_q [ENTRIES];
  logic [CNT_W-1:0]  cnt [ENTRIES];
  logic [PERF_W-1:0] look_d, look_q, mis_d, mis_q;
  logic u_en, u_hit, u_take, l_hit, l_taken;
  logic unused_pc;
  assign unused_pc = ^{bp.lookup_pc_i, bp.upd_pc_i};
  assign l_idx   = bp.lookup_pc_i[IDX_W+1:2];
  assign l_tag   = bp.lookup_pc_i[IDX_W+2 +: TAG_W];
  assign u_idx   = bp.upd_pc_i[IDX_W+1:2];
  assign u_tag   = bp.upd_pc_i[IDX_W+2 +: TAG_W];
  assign u_en    = bp.start_i && bp.upd_valid_i;
  assign u_hit   = valid_q[u_idx] && tag_q[u_idx] == u_tag;
  assign u_take  = bp.upd_taken_i || bp.upd_uncond_i;
  // Lookup reads registered state only, so a same-cycle update is seen next cycle.
  assign l_hit   = bp.start_i && valid_q[l_idx] && tag_q[l_idx] == l_tag;
  assign l_taken = l_hit && cnt[l_idx][CNT_W-1];
  assign bp.pred_hit_o       = l_hit;
  assign bp.pred_taken_o     = l_taken;
  assign bp.pred_target_o    = l_taken ? tgt_q[l_idx] : bp.lookup_pc_i + XLEN'(PC_STEP);
  assign bp.lookup_cnt_o     = look_q;
  assign bp.mispredict_cnt_o = mis_q;
  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    tgt_d   = tgt_q;
    if (u_en && u_take) begin
      valid_d[u_idx] = 1'b1;
      tag_d[u_idx]   = u_tag;
      tgt_d[u_idx]   = bp.upd_target_i;
    end
    look_d = (bp.start_i && look_q != '1) ? look_q + 1'b1 : look_q;
    mis_d  = (u_en && bp.upd_mispredict_i && mis_q != '1) ? mis_q + 1'b1 : mis_q;
  end
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      valid_q <= '0;
      tag_q   <= '{default: '0};
      tgt_q   <= '{default: '0};
      look_q  <= '0;
      mis_q   <= '0;
    end else begin
      valid_q <= valid_d;
      tag_q   <= tag_d;
      tgt_q   <= tgt_d;
      look_q  <= look_d;
      mis_q   <= mis_d;
    end
  end
  for (genvar i = 0; i < ENTRIES; i++) begin : g_cnt
    logic sel;
    assign sel = u_en && u_idx == IDX_W'(i);
    branch_predictor_sat_counter #(.W(CNT_W)) u_cnt (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .inc_i     (sel && u_hit && bp.upd_taken_i),
      .dec_i     (sel && u_hit && !u_take),
      .set_max_i (sel && bp.upd_uncond_i),
      .load_i    (sel && !u_hit && u_take),
      .cnt_o     (cnt[i])
    );
  end
endmodule
